grf_wb_queue: RTL

- Write-port driver for the general register file. It is the producer end of the GRF write interface (we / a3 / wd / pc).
- Merges two writeback sources into the single GRF write port, registered:
  - the in-order pipeline WB stage, which has priority;
  - a multi-cycle mult/div unit, buffered in a small FIFO.
- Exports a per-register pending scoreboard so the hazard unit can stall readers of registers whose values are still queued.

---
 rtl/grf_wb_queue_if.sv | 43 ++++
 rtl/grf_wb_queue.sv | 139 +++++++++++++
 2 files changed

// File: rtl/grf_wb_queue_if.sv
// GRF writeback queue bus: pipeline WB request, mult/div handshake,
// registered GRF write port, hazard queries and occupancy.
// The slave modport is the queue; the master modport is whoever drives it.
interface grf_wb_queue_if #(
  parameter int unsigned PTR_W = 2
);
  logic             wb_we;
  logic [4:0]       wb_a3;
  logic [31:0]      wb_wd;
  logic [31:0]      wb_pc;
  logic             md_valid;
  logic             md_ready;
  logic [4:0]       md_a3;
  logic [31:0]      md_wd;
  logic [31:0]      md_pc;
  logic             grf_we;
  logic [4:0]       grf_a3;
  logic [31:0]      grf_wd;
  logic [31:0]      grf_pc;
  logic [4:0]       rd_a1;
  logic [4:0]       rd_a2;
  logic             busy1;
  logic             busy2;
  logic [PTR_W:0]   q_count;

  modport slave (
    input  wb_we, wb_a3, wb_wd, wb_pc,
    input  md_valid, md_a3, md_wd, md_pc,
    input  rd_a1, rd_a2,
    output md_ready,
    output grf_we, grf_a3, grf_wd, grf_pc,
    output busy1, busy2, q_count
  );

  modport master (
    output wb_we, wb_a3, wb_wd, wb_pc,
    output md_valid, md_a3, md_wd, md_pc,
    output rd_a1, rd_a2,
    input  md_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc,
    input  busy1, busy2, q_count
  );
endinterface

// File: rtl/grf_wb_queue.sv
// GRF write-port driver: merges the pipeline WB stage (priority) with a FIFO
// of mult/div results into one registered GRF write, and exposes a pending
// scoreboard for the hazard unit.
// Optional: define GRF_WBQ_TRACE_EN to print every issued GRF write.
module grf_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic           clk,
  input logic           reset,
  grf_wb_queue_if.slave bus
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  // Entry live bits are cleared on pop, so live implies occupied.
  logic             live_q [DEPTH];
  logic [4:0]       a3_q   [DEPTH];
  logic [31:0]      wd_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;

  logic             grf_we_q, grf_we_d;
  logic [4:0]       grf_a3_q, grf_a3_d;
  logic [31:0]      grf_wd_q, grf_wd_d;
  logic [31:0]      grf_pc_q, grf_pc_d;

  logic full, empty, push, pop, wb_issue;
  logic hit1, hit2;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign wb_issue = bus.wb_we && (bus.wb_a3 != 5'd0);
  assign push     = bus.md_valid && !full;
  assign pop      = !wb_issue && !empty;

  // Issue selection: pipeline first, then FIFO head, else hold address/data.
  always_comb begin
    grf_we_d = 1'b0;
    grf_a3_d = grf_a3_q;
    grf_wd_d = grf_wd_q;
    grf_pc_d = grf_pc_q;
    if (wb_issue) begin
      grf_we_d = 1'b1;
      grf_a3_d = bus.wb_a3;
      grf_wd_d = bus.wb_wd;
      grf_pc_d = bus.wb_pc;
    end else if (!empty) begin
      grf_we_d = live_q[rd_ptr_q];
      grf_a3_d = a3_q[rd_ptr_q];
      grf_wd_d = wd_q[rd_ptr_q];
      grf_pc_d = pc_q[rd_ptr_q];
    end
  end

  // FIFO storage, pointers, occupancy and WAW kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        live_q[PTR_W'(i)] <= 1'b0;
        a3_q[PTR_W'(i)]   <= '0;
        wd_q[PTR_W'(i)]   <= '0;
        pc_q[PTR_W'(i)]   <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // The younger pipeline write supersedes queued writes to the same reg.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wb_issue && live_q[PTR_W'(i)] && (a3_q[PTR_W'(i)] == bus.wb_a3)) begin
          live_q[PTR_W'(i)] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + 1'b1;
      end
      // Push comes last: a new entry is never killed by this cycle's WB write.
      if (push) begin
        live_q[wr_ptr_q] <= (bus.md_a3 != 5'd0);
        a3_q[wr_ptr_q]   <= bus.md_a3;
        wd_q[wr_ptr_q]   <= bus.md_wd;
        pc_q[wr_ptr_q]   <= bus.md_pc;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Registered GRF write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
      grf_pc_q <= '0;
    end else begin
      grf_we_q <= grf_we_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
      grf_pc_q <= grf_pc_d;
    end
  end

  // Scoreboard over queued live entries; the output stage is not included.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live_q[PTR_W'(i)] && (a3_q[PTR_W'(i)] == bus.rd_a1)) hit1 = 1'b1;
      if (live_q[PTR_W'(i)] && (a3_q[PTR_W'(i)] == bus.rd_a2)) hit2 = 1'b1;
    end
  end

  assign bus.busy1    = (bus.rd_a1 != 5'd0) && hit1;
  assign bus.busy2    = (bus.rd_a2 != 5'd0) && hit2;
  assign bus.md_ready = !full;
  assign bus.q_count  = count_q;
  assign bus.grf_we   = grf_we_q;
  assign bus.grf_a3   = grf_a3_q;
  assign bus.grf_wd   = grf_wd_q;
  assign bus.grf_pc   = grf_pc_q;

`ifdef GRF_WBQ_TRACE_EN
  // Trace each real write as it is loaded into the output stage.
  always_ff @(posedge clk) begin
    if (!reset && grf_we_d) begin
      $display("%d@%h: $%d <= %h", $time, grf_pc_d, grf_a3_d, grf_wd_d);
    end
  end
`endif

endmodule
